ab_check_monitor: RTL and testbench
===================================

// Module: ab_check_monitor
// PURPOSE
//  Downstream consumer of the per-clock a&b immediate check. Samples a and b on every posedge of clock.
//  Classifies each enabled cycle as pass (a&b==1) or fail (a&b==0).
//  Accumulates saturating fail statistics, records the timestamp of the first failure and raises a sticky
//  error once a run of consecutive failures reaches RUN_LIMIT. Results are readable by the bench or by a status block.
// PARAMETERS
//  CNT_W     8   width of fail_count (saturating)
//  RUN_W     4   width of cur_run / max_run (saturating)
//  TS_W      16  width of the free-running cycle timestamp (wraps)
//  RUN_LIMIT 3   consecutive-fail length that trips error (1..2**RUN_W-1)
// PORTS
//  clock            in   1      sole clock, posedge
//  reset            in   1      async, active-high
//  enable           in   1      1 = sample a/b this cycle; 0 = hold all statistics
//  clear            in   1      sync clear of statistics and error
//  a                in   1      checked signal a
//  b                in   1      checked signal b
//  fail_count       out  CNT_W  total failing enabled cycles, saturates at all-ones
//  cur_run          out  RUN_W  current consecutive-fail run length
//  max_run          out  RUN_W  longest run seen since reset/clear
//  first_fail_ts    out  TS_W   timestamp of the first failing cycle
//  first_fail_valid out  1      first_fail_ts holds a value
//  error            out  1      sticky trip flag
//  state            out  2      mon_state_t encoding (debug)
// BEHAVIOUR
//  Reset (async, any time): every output and internal register = 0, state = IDLE, timestamp = 0.
//  Timestamp: increments every clock regardless of enable/clear; wraps 2**TS_W-1 -> 0.
//  Latency: a/b sampled at edge N are reflected in all outputs after edge N (registered; no comb paths in->out).
//  Priority per edge: reset > clear > enable=0 > sample.
//  clear=1: fail_count, cur_run, max_run, first_fail_ts, first_fail_valid, error -> 0; state -> IDLE.
//    The a/b sample at that edge is discarded, even if it fails.
//  enable=0 and clear=0: all statistics hold. state -> IDLE unless TRIP; TRIP holds.
//  Fail sample:
//    fail_count += 1 (saturating); cur_run += 1 (saturating).
//    max_run = max(max_run, new cur_run).
//    If first_fail_valid==0: first_fail_ts = current timestamp, first_fail_valid = 1. Never overwritten until clear.
//  Pass sample: cur_run -> 0; other statistics hold.
//  FSM (mon_state_t): IDLE=0, PASS=1, FAIL=2, TRIP=3.
//    IDLE/PASS/FAIL on enabled pass -> PASS.
//    IDLE/PASS/FAIL on enabled fail -> FAIL, or TRIP if new cur_run >= RUN_LIMIT.
//    TRIP: error=1. Exits only on clear or reset. Counting continues in TRIP while enabled.
//  error is 1 exactly when state==TRIP.
//  Saturation: fail_count stays at 2**CNT_W-1; cur_run/max_run stay at 2**RUN_W-1; no wrap.
//  a or b X/Z: treated as fail (a&b !== 1).
// STRUCTURE
//  Package mon_pkg: typedef enum logic [1:0] mon_state_t {IDLE, PASS, FAIL, TRIP}; default width localparams.
//  Sub-module sat_counter #(W): inc, clr, q; saturating up-counter. Three instances: fail_count, cur_run, ts.
//    ts is a wrap-mode instance with sat=0.
//  Remaining logic: FSM next-state, max_run compare, first-fail capture.
// TESTING
//  1 Reset mid-run: assert reset between edges with fail_count=5 -> all outputs 0 immediately, before the next edge.
//  2 a=1,b=0 at edges 2,3,4 after reset (enable=1), pass elsewhere
//    -> fail_count=3, max_run=3, error=1 after edge 4, first_fail_ts=2.
//  3 Fail, pass, fail, pass -> cur_run toggles 1,0,1,0; max_run=1; error stays 0; state FAIL/PASS alternating.
//  4 enable=0 with a=b=0 for 10 cycles -> stats unchanged, state IDLE, timestamp still advances by 10.
//  5 clear and a fail sample on the same edge while in TRIP -> all stats 0, error 0, state IDLE.
//  6 CNT_W=4, 20 consecutive fails -> fail_count=15 (saturated), cur_run=max_run=15 (RUN_W=4), error=1.

Source files
------------

// File: rtl/ab_check_monitor_pkg.sv
// mon_pkg: shared state encoding and default widths for the a&b check monitor.
package mon_pkg;
    typedef enum logic [1:0] {IDLE, PASS, FAIL, TRIP} mon_state_t;
    localparam int CNT_W_DEF     = 8;
    localparam int RUN_W_DEF     = 4;
    localparam int TS_W_DEF      = 16;
    localparam int RUN_LIMIT_DEF = 3;
endpackage

// File: rtl/ab_check_monitor_sat_counter.sv
// sat_counter: up-counter with sync clear; saturates at all-ones when SAT=1, wraps otherwise.
module sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] count_d, count_q;
    always_comb count_d = clr ? '0 : (inc && !(SAT && &count_q)) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
    assign q = count_q;
endmodule

// File: rtl/ab_check_monitor.sv
// ab_check_monitor: classifies each enabled cycle by a&b, keeps saturating fail statistics,
// first-fail timestamp and a sticky error that trips on a long enough run of failures.
module ab_check_monitor import mon_pkg::*; #(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RUN_W     = RUN_W_DEF,
    parameter int TS_W      = TS_W_DEF,
    parameter int RUN_LIMIT = RUN_LIMIT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] fail_count,
    output logic [RUN_W-1:0] cur_run,
    output logic [RUN_W-1:0] max_run,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             first_fail_valid,
    output logic             error,
    output logic [1:0]       state
);
    logic             pass, sample, fail_s;
    logic [TS_W-1:0]  ts;
    logic [RUN_W-1:0] run_next, max_run_d, max_run_q;
    logic [TS_W-1:0]  first_fail_ts_d, first_fail_ts_q;
    logic             first_fail_valid_d, first_fail_valid_q;
    mon_state_t       state_d, state_q;

    // An if on a&&b sends X/Z down the fail path.
    always_comb begin
        pass = 1'b0;
        if (a && b) pass = 1'b1;
        sample = enable && !clear;
        fail_s = sample && !pass;
    end

    sat_counter #(.W(CNT_W), .SAT(1'b1)) u_fail (
        .clock(clock), .reset(reset), .inc(fail_s), .clr(clear), .q(fail_count)
    );
    sat_counter #(.W(RUN_W), .SAT(1'b1)) u_run (
        .clock(clock), .reset(reset), .inc(fail_s), .clr(clear || (sample && pass)), .q(cur_run)
    );
    sat_counter #(.W(TS_W), .SAT(1'b0)) u_ts (
        .clock(clock), .reset(reset), .inc(1'b1), .clr(1'b0), .q(ts)
    );

    assign run_next = (&cur_run) ? cur_run : cur_run + 1'b1;

    always_comb begin
        max_run_d          = max_run_q;
        first_fail_ts_d    = first_fail_ts_q;
        first_fail_valid_d = first_fail_valid_q;
        state_d            = state_q;
        if (clear) begin
            max_run_d          = '0;
            first_fail_ts_d    = '0;
            first_fail_valid_d = 1'b0;
            state_d            = IDLE;
        end else if (!enable) begin
            state_d = (state_q == TRIP) ? TRIP : IDLE;
        end else begin
            if (!pass) begin
                max_run_d = (run_next > max_run_q) ? run_next : max_run_q;
                if (!first_fail_valid_q) begin
                    first_fail_ts_d    = ts;
                    first_fail_valid_d = 1'b1;
                end
            end
            state_d = (state_q == TRIP) ? TRIP :
                      pass ? PASS :
                      (run_next >= RUN_W'(RUN_LIMIT)) ? TRIP : FAIL;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            max_run_q          <= '0;
            first_fail_ts_q    <= '0;
            first_fail_valid_q <= 1'b0;
            state_q            <= IDLE;
        end else begin
            max_run_q          <= max_run_d;
            first_fail_ts_q    <= first_fail_ts_d;
            first_fail_valid_q <= first_fail_valid_d;
            state_q            <= state_d;
        end
    end

    assign max_run          = max_run_q;
    assign first_fail_ts    = first_fail_ts_q;
    assign first_fail_valid = first_fail_valid_q;
    assign error            = (state_q == TRIP);
    assign state            = state_q;
endmodule

// File: tb/tb_ab_check_monitor.sv
// tb_ab_check_monitor: directed scenarios plus random traffic against a counting model, scoreboarded.
module tb_ab_check_monitor;
    logic clk = 1'b0;
    logic rst, enable, clear, a, b;
    logic [7:0]  fail_count;
    logic [3:0]  cur_run, max_run, fail_count4, cur_run4, max_run4;
    logic [15:0] first_fail_ts, first_fail_ts4;
    logic        first_fail_valid, error, first_fail_valid4, error4;
    logic [1:0]  state, state4;

    typedef struct {int fc; int fc4; int cur; int mx; int fts; int fv; int st;} exp_t;
    exp_t exp_q[$];
    int checks = 0, failures = 0;

    int m_fails, m_run, m_max, m_fts, m_fv, m_trip, m_last, m_ts;

    always #5 clk = ~clk;

    ab_check_monitor dut (
        .clock(clk), .reset(rst), .enable(enable), .clear(clear), .a(a), .b(b),
        .fail_count(fail_count), .cur_run(cur_run), .max_run(max_run),
        .first_fail_ts(first_fail_ts), .first_fail_valid(first_fail_valid),
        .error(error), .state(state)
    );
    ab_check_monitor #(.CNT_W(4)) dut4 (
        .clock(clk), .reset(rst), .enable(enable), .clear(clear), .a(a), .b(b),
        .fail_count(fail_count4), .cur_run(cur_run4), .max_run(max_run4),
        .first_fail_ts(first_fail_ts4), .first_fail_valid(first_fail_valid4),
        .error(error4), .state(state4)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_fails = 0; m_run = 0; m_max = 0; m_fts = 0; m_fv = 0; m_trip = 0; m_last = 0; m_ts = 0;
    endtask

    task automatic step(input logic en, input logic cl, input logic av, input logic bv);
        exp_t e;
        enable = en; clear = cl; a = av; b = bv;
        if (cl) begin
            m_fails = 0; m_run = 0; m_max = 0; m_fts = 0; m_fv = 0; m_trip = 0; m_last = 0;
        end else if (!en) begin
            m_last = 0;
        end else if (!(av === 1'b1 && bv === 1'b1)) begin
            m_fails++; m_run++;
            if (m_run > m_max) m_max = m_run;
            if (m_fv == 0) begin m_fv = 1; m_fts = m_ts; end
            if (m_run >= 3) m_trip = 1;
            m_last = 2;
        end else begin
            m_run = 0; m_last = 1;
        end
        m_ts = (m_ts + 1) % 65536;
        e.fc = sat(m_fails, 255); e.fc4 = sat(m_fails, 15);
        e.cur = sat(m_run, 15); e.mx = sat(m_max, 15);
        e.fts = m_fts; e.fv = m_fv; e.st = m_trip ? 3 : m_last;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("fail_count", int'(fail_count), e.fc);
            chk("fail_count_w4", int'(fail_count4), e.fc4);
            chk("cur_run", int'(cur_run), e.cur);
            chk("max_run", int'(max_run), e.mx);
            chk("first_fail_ts", int'(first_fail_ts), e.fts);
            chk("first_fail_valid", int'(first_fail_valid), e.fv);
            chk("state", int'(state), e.st);
            chk("error", int'(error), int'(e.st == 3));
            chk("cur_run_w4", int'(cur_run4), e.cur);
            chk("state_w4", int'(state4), e.st);
            chk("error_w4", int'(error4), int'(e.st == 3));
            chk("max_run_w4", int'(max_run4), e.mx);
            chk("first_fail_ts_w4", int'(first_fail_ts4), e.fts);
            chk("first_fail_valid_w4", int'(first_fail_valid4), e.fv);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_fail_count"}, int'(fail_count), 0);
        chk({tag, "_cur_run"}, int'(cur_run), 0);
        chk({tag, "_max_run"}, int'(max_run), 0);
        chk({tag, "_first_fail_ts"}, int'(first_fail_ts), 0);
        chk({tag, "_first_fail_valid"}, int'(first_fail_valid), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_fail_count_w4"}, int'(fail_count4), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk); #1;
        chk("pre_reset_fail_count", int'(fail_count), m_fails);
        rst = 1'b1;
        #1 check_zero("async_reset");
        exp_q.delete();
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; a = 1'b0; b = 1'b0;
        model_reset();
        #11 check_zero("reset");
        #1 rst = 1'b0;
        repeat (5) step(1, 0, 1, 0);
        mid_reset();
        step(1, 0, 1, 1); step(1, 0, 1, 1);
        repeat (3) step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        step(1, 1, 0, 0);
        repeat (2) begin step(1, 0, 0, 1); step(1, 0, 1, 1); end
        repeat (10) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        repeat (20) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic en, cl, av, bv;
            en = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 39) == 0);
            av = ($urandom_range(0, 4) != 0);
            bv = ($urandom_range(0, 4) != 0);
            step(en, cl, av, bv);
            if (i == 300) mid_reset();
        end
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
